onebit_sequencer: RTL and testbench
===================================

// Module: onebit_sequencer
// PURPOSE
// Control side of the one-bit CPU: stores the 2-word program, drives the 2-bit code word
//   into the combinational ALU each cycle, and registers the ALU's reg/pc results back.
// Program is loaded over a valid/ready port. A start/run_cycles command then executes
//   exactly N instructions, reports done, and returns to idle.
// PARAMETERS
// CYC_W    8   width of run_cycles and the internal step counter (max run 2**CYC_W-1)
// PORTS
// clk          in   1      single clock, rising edge
// rst          in   1      asynchronous, active-high reset
// ld_valid     in   1      program-load word valid
// ld_ready     out  1      load accepted this cycle when ld_valid&&ld_ready
// ld_addr      in   1      program address (0..1)
// ld_code      in   2      {cmd,arg}; cmd 0 = XOR reg with arg, cmd 1 = JMP to arg
// start        in   1      begin execution (sampled in IDLE only)
// run_cycles   in   CYC_W  instruction count, latched on start
// halt         in   1      abort a run (sampled in RUN only)
// busy         out  1      1 while in RUN
// done         out  1      one-cycle pulse at end of run (normal, zero-length or halted)
// code_out     out  2      code word to ALU
// reg_q        out  1      CPU register state, fed to ALU reg_in
// pc_q         out  1      CPU program counter, fed to ALU pc_in
// alu_reg_out  in   1      ALU next-reg result
// alu_pc_out   in   1      ALU next-pc result
// BEHAVIOUR
// Reset (async, any state): state=IDLE; mem[0]=mem[1]=2'b00 (XOR 0 = nop); reg_q=0,
//   pc_q=0, counter=0, busy=0, done=0. Reset mid-run aborts it; no done pulse.
// States: IDLE -> RUN -> DONE -> IDLE. DONE lasts exactly one cycle (done=1).
// ld_ready = (state==IDLE). Handshake writes mem[ld_addr]<=ld_code on that edge;
//   ld_valid outside IDLE is ignored (no write, no stall, no error).
// IDLE & start: counter<=run_cycles, reg_q<=0, pc_q<=0; next state RUN if run_cycles!=0,
//   else DONE (zero-length run: done pulses next cycle, reg_q/pc_q = 0).
// start and load handshake in the same IDLE cycle: both take effect; run uses new word.
// code_out = mem[pc_q] while state==RUN, else 2'b00. Combinational ALU path, 0 latency.
// RUN, halt=0: each edge commits reg_q<=alu_reg_out, pc_q<=alu_pc_out, counter<=counter-1;
//   the edge where counter==1 commits the last step and goes to DONE. So exactly
//   run_cycles instructions execute; busy high for run_cycles cycles.
// RUN, halt=1: that cycle's step is NOT committed (reg_q/pc_q hold); go to DONE.
// start during RUN/DONE ignored. Counter never wraps (only decrements from >=1).
// reg_q/pc_q hold their final values through DONE and IDLE until the next start.
// STRUCTURE
// Shared package (onebit_pkg): CMD_XOR=1'b0, CMD_JMP=1'b1, code word typedef {cmd,arg},
//   state enum {IDLE,RUN,DONE}, NOP_CODE=2'b00.
// One sub-module: onebit_prog_mem (2x2-bit regfile, 1 write port, 1 async read, async clear).
// ALU stays external; the top-level CPU wires code_out/reg_q/pc_q to it.
// TESTING (bench instantiates this block plus the ALU)
// After reset, no load, start run_cycles=3 -> busy 3 cycles, done pulse; reg_q=0, pc_q=1.
// Load mem0=01, mem1=10; run_cycles=3 -> per-step (reg,pc)=(1,1),(1,0),(0,1); end reg_q=0, pc_q=1.
// Load mem0=01, mem1=11; run_cycles=5 -> pc locks at 1 after step 1; end reg_q=1, pc_q=1.
// start with run_cycles=0 -> busy never high, done pulses the next cycle, reg_q=pc_q=0.
// Program as case 2, run 200 cycles, halt at step 2 -> reg_q=1, pc_q=1 held; done 1 cycle.
// ld_valid during RUN -> ld_ready=0, mem unchanged; rst mid-run -> all outputs reset, no done.

Source files
------------

// File: rtl/onebit_pkg.sv
// -----------------------------------------------------------------------------
// onebit_pkg
// Shared definitions for the one-bit CPU control side: instruction encoding,
// code word layout, sequencer state encoding and the power-on program word.
// A code word is {cmd, arg}:
//   cmd = CMD_XOR : reg <= reg ^ arg, pc advances to the other word
//   cmd = CMD_JMP : reg holds,        pc <= arg
// -----------------------------------------------------------------------------
package onebit_pkg;

  localparam logic CMD_XOR = 1'b0;
  localparam logic CMD_JMP = 1'b1;

  typedef struct packed {
    logic cmd;
    logic arg;
  } code_t;

  // XOR with 0 leaves the register untouched, so a cleared memory is a nop loop.
  localparam code_t NOP_CODE = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Decodes the command field of a code word.
  function automatic logic is_jump(input code_t code);
    return (code.cmd == CMD_JMP);
  endfunction

endpackage : onebit_pkg

// File: rtl/onebit_prog_mem.sv
// -----------------------------------------------------------------------------
// onebit_prog_mem
// Two-entry program memory for the one-bit CPU. One synchronous write port,
// one asynchronous (combinational) read port, asynchronous clear to NOP_CODE.
// Ports:
//   clk    in  1  rising-edge clock
//   rst    in  1  asynchronous active-high clear of both words
//   we     in  1  write enable
//   waddr  in  1  write address
//   wdata  in  2  write data {cmd,arg}
//   raddr  in  1  read address
//   rdata  out 2  word at raddr, same cycle
// -----------------------------------------------------------------------------
module onebit_prog_mem
  import onebit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic       waddr,
  input  logic [1:0] wdata,
  input  logic       raddr,
  output logic [1:0] rdata
);

  code_t mem0_r;
  code_t mem1_r;

  // Word 0 storage: cleared on reset, written when addressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_r <= NOP_CODE;
    end else if (we && (waddr == 1'b0)) begin
      mem0_r <= code_t'(wdata);
    end
  end

  // Word 1 storage: cleared on reset, written when addressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem1_r <= NOP_CODE;
    end else if (we && (waddr == 1'b1)) begin
      mem1_r <= code_t'(wdata);
    end
  end

  // Combinational read so the ALU sees the current word with no latency.
  always_comb begin
    rdata = 2'b00;
    if (raddr == 1'b1) begin
      rdata = mem1_r;
    end else begin
      rdata = mem0_r;
    end
  end

endmodule : onebit_prog_mem

// File: rtl/onebit_sequencer.sv
// -----------------------------------------------------------------------------
// onebit_sequencer
// Control side of the one-bit CPU. Holds the two-word program, presents the
// current code word to the external combinational ALU and commits the ALU's
// next reg/pc back each RUN cycle. A start command latches an instruction
// count; exactly that many instructions execute (or fewer if halted), then a
// single-cycle done pulse is raised and the sequencer returns to IDLE.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   ld_valid/ld_ready  program-load handshake (ready only in IDLE)
//   ld_addr, ld_code   word address and {cmd,arg} value to load
//   start, run_cycles  launch a run of run_cycles instructions (IDLE only)
//   halt               abort a run; the step of that cycle is discarded
//   busy, done         in RUN / one-cycle end-of-run pulse
//   code_out           code word to the ALU (NOP outside RUN)
//   reg_q, pc_q        architectural register and program counter
//   alu_reg_out/pc_out ALU results for the current step
// -----------------------------------------------------------------------------
module onebit_sequencer
  import onebit_pkg::*;
#(
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             ld_addr,
  input  logic [1:0]       ld_code,
  input  logic             start,
  input  logic [CYC_W-1:0] run_cycles,
  input  logic             halt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       code_out,
  output logic             reg_q,
  output logic             pc_q,
  input  logic             alu_reg_out,
  input  logic             alu_pc_out
);

  localparam logic [CYC_W-1:0] CNT_ZERO = {CYC_W{1'b0}};
  localparam logic [CYC_W-1:0] CNT_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [CYC_W-1:0] count_r;
  logic [CYC_W-1:0] count_s;
  logic             reg_r;
  logic             reg_s;
  logic             pc_r;
  logic             pc_s;
  logic             busy_r;
  logic             busy_s;
  logic             done_r;
  logic             done_s;
  logic             ready_r;
  logic             ready_s;
  logic             mem_we_s;
  logic [1:0]       mem_rd_s;

  // A load is accepted only while the sequencer reports ready (IDLE);
  // ld_valid in any other state is silently dropped.
  assign mem_we_s = ld_valid & ready_r;

  onebit_prog_mem u_prog_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we_s),
    .waddr (ld_addr),
    .wdata (ld_code),
    .raddr (pc_r),
    .rdata (mem_rd_s)
  );

  // Next-state, counter and architectural state update.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    reg_s   = reg_r;
    pc_s    = pc_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          count_s = run_cycles;
          reg_s   = 1'b0;
          pc_s    = 1'b0;
          if (run_cycles != CNT_ZERO) begin
            state_s = RUN;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (halt) begin
          // Discard this cycle's ALU result and end the run.
          state_s = DONE;
        end else begin
          reg_s   = alu_reg_out;
          pc_s    = alu_pc_out;
          // count_r is always >= 1 in RUN, so this never wraps.
          count_s = count_r - CNT_ONE;
          if (count_r == CNT_ONE) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state so they can be registered
  // alongside it and stay glitch-free at the outputs.
  always_comb begin
    busy_s  = 1'b0;
    done_s  = 1'b0;
    ready_s = 1'b0;
    case (state_s)
      IDLE:    ready_s = 1'b1;
      RUN:     busy_s  = 1'b1;
      DONE:    done_s  = 1'b1;
      default: ready_s = 1'b0;
    endcase
  end

  // Sequencer state, step counter and CPU register/pc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= CNT_ZERO;
      reg_r   <= 1'b0;
      pc_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      reg_r   <= reg_s;
      pc_r    <= pc_s;
    end
  end

  // Registered status outputs; reset lands in IDLE so ready starts high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      busy_r  <= busy_s;
      done_r  <= done_s;
      ready_r <= ready_s;
    end
  end

  assign ld_ready = ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign reg_q    = reg_r;
  assign pc_q     = pc_r;

  // The ALU path is combinational: the stored word goes straight out while
  // running, and a nop is presented otherwise so the ALU sees a stable input.
  assign code_out = busy_r ? mem_rd_s : NOP_CODE;

endmodule : onebit_sequencer

// File: tb/tb_onebit_sequencer.sv
// -----------------------------------------------------------------------------
// tb_onebit_sequencer
// Bench for onebit_sequencer with a behavioural one-bit ALU attached.
// -----------------------------------------------------------------------------
module tb_onebit_sequencer;

  logic       clk;
  logic       rst;
  logic       ld_valid;
  logic       ld_ready;
  logic       ld_addr;
  logic [1:0] ld_code;
  logic       start;
  logic [7:0] run_cycles;
  logic       halt;
  logic       busy;
  logic       done;
  logic [1:0] code_out;
  logic       reg_q;
  logic       pc_q;
  logic       alu_reg_out;
  logic       alu_pc_out;

  int n_tests;
  int n_fail;

  // Instruction semantics: returns {next_reg, next_pc}.
  function automatic logic [1:0] isa_step(input logic [1:0] code, input logic r, input logic p);
    if (code[1]) return {r, code[0]};
    else         return {r ^ code[0], ~p};
  endfunction

  // External ALU.
  assign {alu_reg_out, alu_pc_out} = isa_step(code_out, reg_q, pc_q);

  onebit_sequencer #(.CYC_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_code     (ld_code),
    .start       (start),
    .run_cycles  (run_cycles),
    .halt        (halt),
    .busy        (busy),
    .done        (done),
    .code_out    (code_out),
    .reg_q       (reg_q),
    .pc_q        (pc_q),
    .alu_reg_out (alu_reg_out),
    .alu_pc_out  (alu_pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       do_load;
    logic [1:0] m0;
    logic [1:0] m1;
    logic       co_ld;      // load word 0 with aux in the start cycle
    logic       ld_in_run;  // drive ld_valid word 0 = aux during RUN
    logic [1:0] aux;
    logic [7:0] n;
    int         halt_step;  // RUN cycle on which halt is raised (0 = none)
    logic       exp_reg;
    logic       exp_pc;
    int         exp_busy;
  } vec_t;

  vec_t       vecs[11];
  logic [1:0] prog0;
  logic [1:0] prog1;
  logic [1:0] sb_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_word(input logic a, input logic [1:0] c);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_code  = c;
    check("ld_ready_idle", {7'd0, ld_ready}, 8'd1);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    if (a) prog1 = c;
    else   prog0 = c;
  endtask

  task automatic run_cmd(input vec_t v);
    logic       m_reg;
    logic       m_pc;
    logic [1:0] nx;
    logic [1:0] exp_code;
    logic [1:0] got;
    int         steps;
    int         busy_cnt;
    int         done_cnt;
    logic       stepped;

    @(negedge clk);
    start      = 1'b1;
    run_cycles = v.n;
    if (v.co_ld) begin
      ld_valid = 1'b1;
      ld_addr  = 1'b0;
      ld_code  = v.aux;
      prog0    = v.aux;
    end
    // Scoreboard: expected (reg,pc) after each committed step.
    sb_q.delete();
    m_reg = 1'b0;
    m_pc  = 1'b0;
    steps = (v.halt_step > 0) ? v.halt_step - 1 : int'(v.n);
    for (int s = 0; s < steps; s++) begin
      nx = isa_step(m_pc ? prog1 : prog0, m_reg, m_pc);
      sb_q.push_back(nx);
      m_reg = nx[1];
      m_pc  = nx[0];
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    ld_valid = 1'b0;

    m_pc     = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    stepped  = 1'b0;
    for (int c = 0; c < v.exp_busy + 6; c++) begin
      @(negedge clk);
      if (stepped) begin
        if (sb_q.size() == 0) begin
          check("extra_step", 8'd1, 8'd0);
        end else begin
          nx = sb_q.pop_front();
          check("step_reg_pc", {6'd0, reg_q, pc_q}, {6'd0, nx});
          m_pc = nx[0];
        end
      end
      stepped = 1'b0;
      if (busy) begin
        busy_cnt++;
        exp_code = m_pc ? prog1 : prog0;
        check("code_out_run", {6'd0, code_out}, {6'd0, exp_code});
        if (v.ld_in_run) begin
          ld_valid = 1'b1;
          ld_addr  = 1'b0;
          ld_code  = v.aux;
          check("ld_ready_run", {7'd0, ld_ready}, 8'd0);
        end
        halt    = (busy_cnt == v.halt_step);
        stepped = ~halt;
      end else begin
        halt     = 1'b0;
        ld_valid = 1'b0;
        if (done) done_cnt++;
      end
    end
    halt     = 1'b0;
    ld_valid = 1'b0;
    got = {reg_q, pc_q};
    check("busy_cycles", 8'(busy_cnt), 8'(v.exp_busy));
    check("done_pulses", 8'(done_cnt), 8'd1);
    check("final_reg_pc", {6'd0, got}, {6'd0, v.exp_reg, v.exp_pc});
    check("sb_empty", 8'(sb_q.size()), 8'd0);
    check("idle_ready", {5'd0, ld_ready, busy, done}, 8'b100);
    check("idle_code", {6'd0, code_out}, 8'd0);
  endtask

  task automatic reset_mid_run();
    int done_seen;
    @(negedge clk);
    start      = 1'b1;
    run_cycles = 8'd50;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_rst", {7'd0, busy}, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_outputs", {2'd0, busy, done, ld_ready, reg_q, pc_q, 1'b0}, 8'b0000_1000);
    check("rst_code_out", {6'd0, code_out}, 8'd0);
    prog0 = 2'b00;
    prog1 = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("no_done_after_rst", 8'(done_seen), 8'd0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    ld_valid   = 1'b0;
    ld_addr    = 1'b0;
    ld_code    = 2'b00;
    start      = 1'b0;
    run_cycles = 8'd0;
    halt       = 1'b0;
    prog0      = 2'b00;
    prog1      = 2'b00;

    //          load  m0     m1     co    inrun aux    n       halt exp_r exp_p busy
    vecs[0]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 8'd3,   0, 1'b0, 1'b1, 3};
    vecs[1]  = '{1'b1, 2'b01, 2'b10, 1'b0, 1'b0, 2'b00, 8'd3,   0, 1'b0, 1'b1, 3};
    vecs[2]  = '{1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 2'b00, 8'd5,   0, 1'b1, 1'b1, 5};
    vecs[3]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 8'd0,   0, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b1, 2'b01, 2'b10, 1'b0, 1'b0, 2'b00, 8'd200, 2, 1'b1, 1'b1, 2};
    vecs[5]  = '{1'b1, 2'b00, 2'b11, 1'b0, 1'b0, 2'b00, 8'd4,   0, 1'b0, 1'b1, 4};
    vecs[6]  = '{1'b1, 2'b11, 2'b01, 1'b0, 1'b0, 2'b00, 8'd2,   0, 1'b1, 1'b0, 2};
    vecs[7]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01, 8'd4,   0, 1'b0, 1'b0, 4};
    vecs[8]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 8'd1,   0, 1'b0, 1'b1, 1};
    vecs[9]  = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 8'd1,   0, 1'b1, 1'b1, 1};
    vecs[10] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 8'd2,   0, 1'b1, 1'b0, 2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {2'd0, busy, done, ld_ready, reg_q, pc_q, 1'b0}, 8'b0000_1000);
    check("reset_code_out", {6'd0, code_out}, 8'd0);

    for (int i = 0; i < 11; i++) begin
      if (i == 9) reset_mid_run();
      if (vecs[i].do_load) begin
        load_word(1'b0, vecs[i].m0);
        load_word(1'b1, vecs[i].m1);
      end
      run_cmd(vecs[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_onebit_sequencer
